hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline stall/flush controller for the 5-stage MIPS core; the counterpart to forwarding. Forwarding resolves
//  every RAW case it can; this block stalls or squashes the cases it cannot: load-use, jr-after-load, taken
//  branch/jump redirect, and I/D memory wait. Drives per-latch enable/flush and keeps stall/flush perf counters.
// PARAMETERS
//  CNT_W  32  width of perf counters stall_cnt / flush_cnt (saturating)
// PORTS
//  CLK           in   1      core clock; all state updates on posedge
//  nRST          in   1      synchronous, active-low reset
//  ihit          in   1      instruction fetch complete this cycle
//  dhit          in   1      data access in MEM complete this cycle
//  opcode_de     in   6      opcode of instr in DECODE
//  rs_de, rt_de  in   5      source regs of instr in DECODE
//  uses_rt_de    in   1      DECODE instr reads rt (R-type, BEQ, BNE, SW)
//  regDst_ex     in   5      dest reg of instr in EXECUTE
//  regWr_ex      in   1      EXECUTE instr writes reg file
//  regSel_ex     in   2      EXECUTE writeback source; 2'b11 = dmemload (load)
//  dREN_me       in   1      MEM instr reads dmem
//  dWEN_me       in   1      MEM instr writes dmem
//  redirect_ex   in   1      taken branch / jump / jr resolved in EXECUTE; PC is redirected
//  pc_en         out  1      PC register load enable
//  fd_en, fd_flush   out 1   FETCH/DECODE latch enable / clear-to-NOP
//  de_en, de_flush   out 1   DECODE/EXECUTE latch enable / clear-to-NOP
//  em_en, em_flush   out 1   EXECUTE/MEM latch enable / clear-to-NOP
//  mw_en         out  1      MEM/WB latch enable
//  stall_cnt     out  CNT_W  cycles with pc_en=0 since reset
//  flush_cnt     out  CNT_W  cycles with fd_flush or de_flush asserted since reset
// BEHAVIOUR
//  Reset: nRST=0 at posedge -> state RUN, counters 0. While nRST=0 outputs forced combinationally:
//   all *_en=0, all *_flush=1, counters read 0.
//  Hazard terms (combinational; reg 0 never hazards):
//   ld_use = regWr_ex & regSel_ex==2'b11 & regDst_ex!=0 & (rs_de==regDst_ex | uses_rt_de & rt_de==regDst_ex)
//   (jr: opcode_de==JR compares rs_de only; uses same ld_use term -> one bubble; MEM-stage forwarding covers rest)
//   dwait  = (dREN_me|dWEN_me) & ~dhit
//  FSM states: RUN, BUBBLE, DWAIT.
//   RUN   : dwait -> DWAIT; else ld_use -> BUBBLE; else RUN.
//   BUBBLE: exactly one bubble cycle has been inserted; -> DWAIT if dwait, else RUN. ld_use cannot re-fire
//           against the same load (it is now in MEM).
//   DWAIT : stay while dwait; -> RUN on dhit. A ld_use pending on entry is re-evaluated in RUN (inputs frozen).
//  Output priority per cycle (highest first), zero-latency from inputs + state:
//   1 dwait          : pc_en=fd_en=de_en=em_en=mw_en=0, no flush (whole pipe frozen).
//   2 redirect_ex    : pc_en=1, fd_flush=1, de_flush=1, em_en=mw_en=1. Overrides ld_use (younger instr squashed).
//                      If ~ihit same cycle, fd_flush still 1 (wrong-path fetch discarded).
//   3 ld_use (RUN)   : pc_en=0, fd_en=0, de_flush=1 (bubble into EX), em_en=mw_en=1.
//   4 ~ihit          : pc_en=0, fd_flush=1, de_en=em_en=mw_en=1 (NOP enters DECODE, older instr drain).
//   5 otherwise      : all *_en=1, all *_flush=0.
//  flush has priority over en on the same latch; en=0 & flush=0 means hold.
//  Counters: +1 per cycle per condition, saturate at all-ones, never wrap; not incremented while nRST=0.
//  Reset mid-operation: any state -> RUN next edge; in-flight dwait/bubble discarded.
// STRUCTURE
//  cpu_types_pkg: add typedef enum logic [1:0] {HZ_RUN, HZ_BUBBLE, HZ_DWAIT} hz_state_t;
//   localparam REGSEL_LOAD = 2'b11; reuse existing opcode_t (JR, BEQ, BNE, SW).
//  Interface hazard_unit_if (modport hu / dp), matching forwarding_unit_if style.
//  One sub-module: sat_counter #(CNT_W) (inc, CLK, nRST -> count), instanced twice.
// TESTING
//  Load-use: EX lw $3 (regSel 11, regWr 1), DE add rs=$3 -> cycle0 pc_en=0,fd_en=0,de_flush=1; cycle1 all en=1.
//  $zero: EX lw $0, DE add rs=$0 -> no stall, stall_cnt unchanged.
//  Redirect wins: redirect_ex=1 with ld_use=1 -> fd_flush=de_flush=1, pc_en=1; flush_cnt +1.
//  Dmem wait: dREN_me=1, dhit=0 for 3 cycles then 1 -> 3 cycles all en=0, state DWAIT; 4th cycle RUN, en=1.
//  Ifetch miss: ihit=0 2 cycles -> pc_en=0, fd_flush=1, de_en=1; stall_cnt +2.
//  Reset: nRST=0 during DWAIT -> next edge RUN, counters 0; force counters to 2^CNT_W-1 -> stay saturated.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, writeback
// select for loads, and the opcodes the load-use detector cares about.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_BUBBLE = 2'd1,
    HZ_DWAIT  = 2'd2
  } hz_state_t;

  localparam logic [1:0] REGSEL_LOAD = 2'b11;

  // JR uses the core's internal decode encoding, not the MIPS R-type funct.
  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    LW    = 6'h23,
    SW    = 6'h2b,
    JR    = 6'h3f
  } opcode_t;

  function automatic logic ld_hazard(
    input logic       regwr,
    input logic [1:0] regsel,
    input logic [4:0] dst,
    input logic [5:0] opcode,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    logic rt_hit;
    rt_hit = uses_rt && (opcode != JR) && (rt == dst);
    return regwr && (regsel == REGSEL_LOAD) && (dst != 5'd0) && ((rs == dst) || rt_hit);
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating event counter; reads zero while reset is held.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = nRST ? count_q : {CNT_W{1'b0}};

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, redirect
// squashes, I/D memory waits, plus saturating stall/flush counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [5:0]       opcode_de,
  input  logic [4:0]       rs_de,
  input  logic [4:0]       rt_de,
  input  logic             uses_rt_de,
  input  logic [4:0]       regDst_ex,
  input  logic             regWr_ex,
  input  logic [1:0]       regSel_ex,
  input  logic             dREN_me,
  input  logic             dWEN_me,
  input  logic             redirect_ex,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             de_en,
  output logic             de_flush,
  output logic             em_en,
  output logic             em_flush,
  output logic             mw_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hz_state_t state_q;
  hz_state_t state_d;
  logic      ld_use;
  logic      dwait;

  assign ld_use = ld_hazard(regWr_ex, regSel_ex, regDst_ex, opcode_de, rs_de, rt_de, uses_rt_de);
  assign dwait  = (dREN_me || dWEN_me) && !dhit;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_RUN: begin
        if (dwait)       state_d = HZ_DWAIT;
        else if (ld_use) state_d = HZ_BUBBLE;
        else             state_d = HZ_RUN;
      end
      HZ_BUBBLE: state_d = dwait ? HZ_DWAIT : HZ_RUN;
      HZ_DWAIT:  state_d = dwait ? HZ_DWAIT : HZ_RUN;
      default:   state_d = HZ_RUN;
    endcase
  end

  // A flushed latch keeps en=1: flush dominates, so the value is irrelevant.
  always_comb begin
    pc_en    = 1'b1;
    fd_en    = 1'b1;
    de_en    = 1'b1;
    em_en    = 1'b1;
    mw_en    = 1'b1;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    em_flush = 1'b0;
    if (!nRST) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_en    = 1'b0;
      em_en    = 1'b0;
      mw_en    = 1'b0;
      fd_flush = 1'b1;
      de_flush = 1'b1;
      em_flush = 1'b1;
    end else if (dwait) begin
      pc_en = 1'b0;
      fd_en = 1'b0;
      de_en = 1'b0;
      em_en = 1'b0;
      mw_en = 1'b0;
    end else if (redirect_ex) begin
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (ld_use && (state_q == HZ_RUN)) begin
      pc_en    = 1'b0;
      fd_en    = 1'b0;
      de_flush = 1'b1;
    end else if (!ihit) begin
      pc_en    = 1'b0;
      fd_flush = 1'b1;
    end else begin
      pc_en = 1'b1;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (!pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (fd_flush || de_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (small counters to reach saturation).
module tb_hazard_unit;

  localparam int CW = 4;

  // control bundle order: pc_en fd_en fd_flush de_en de_flush em_en em_flush mw_en
  localparam logic [7:0] C_RST   = 8'b00101010;
  localparam logic [7:0] C_IDLE  = 8'b11010101;
  localparam logic [7:0] C_LU    = 8'b00011101;
  localparam logic [7:0] C_REDIR = 8'b11111101;
  localparam logic [7:0] C_FRZ   = 8'b00000000;
  localparam logic [7:0] C_IMISS = 8'b01110101;

  logic          CLK = 1'b0;
  logic          nRST, ihit, dhit, uses_rt_de, regWr_ex, dREN_me, dWEN_me, redirect_ex;
  logic [5:0]    opcode_de;
  logic [4:0]    rs_de, rt_de, regDst_ex;
  logic [1:0]    regSel_ex;
  logic          pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [7:0]    ctl;
  int            pass_cnt = 0;
  int            total_cnt = 0;
  int            exp_stall = 0;
  int            exp_flush = 0;

  assign ctl = {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush, mw_en};

  always #5 CLK = ~CLK;

  hazard_unit #(.CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .opcode_de(opcode_de),
    .rs_de(rs_de), .rt_de(rt_de), .uses_rt_de(uses_rt_de), .regDst_ex(regDst_ex),
    .regWr_ex(regWr_ex), .regSel_ex(regSel_ex), .dREN_me(dREN_me), .dWEN_me(dWEN_me),
    .redirect_ex(redirect_ex), .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush),
    .de_en(de_en), .de_flush(de_flush), .em_en(em_en), .em_flush(em_flush),
    .mw_en(mw_en), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    nRST = 1'b1; ihit = 1'b1; dhit = 1'b0; opcode_de = 6'h00;
    rs_de = 5'd0; rt_de = 5'd0; uses_rt_de = 1'b0; regDst_ex = 5'd0;
    regWr_ex = 1'b0; regSel_ex = 2'b00; dREN_me = 1'b0; dWEN_me = 1'b0; redirect_ex = 1'b0;
  endtask

  task automatic set_lw(input logic [4:0] dst);
    regWr_ex = 1'b1; regSel_ex = 2'b11; regDst_ex = dst;
  endtask

  task automatic test_reset();
    set_idle(); nRST = 1'b0; set_lw(5'd3); rs_de = 5'd3;
    @(negedge CLK);
    total_cnt++; if (ctl !== C_RST) $display("FAIL reset_ctl got %b want %b", ctl, C_RST); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0)
      $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); else pass_cnt++;
    step(); step();
    set_idle();
  endtask

  task automatic test_idle();
    set_idle();
    @(negedge CLK);
    total_cnt++; if (ctl !== C_IDLE) $display("FAIL idle_ctl got %b want %b", ctl, C_IDLE); else pass_cnt++;
    step();
    total_cnt++; if (stall_cnt !== 4'(exp_stall) || flush_cnt !== 4'(exp_flush))
      $display("FAIL idle_cnt got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush); else pass_cnt++;
  endtask

  task automatic test_load_use();
    set_idle(); set_lw(5'd3); rs_de = 5'd3;
    @(negedge CLK);
    total_cnt++; if (ctl !== C_LU) $display("FAIL lu_rs got %b want %b", ctl, C_LU); else pass_cnt++;
    step(); exp_stall += 1; exp_flush += 1;
    @(negedge CLK);
    total_cnt++; if (ctl !== C_IDLE) $display("FAIL lu_bubble got %b want %b", ctl, C_IDLE); else pass_cnt++;
    step();
    total_cnt++; if (stall_cnt !== 4'(exp_stall) || flush_cnt !== 4'(exp_flush))
      $display("FAIL lu_cnt got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush); else pass_cnt++;
    set_idle(); set_lw(5'd5); rs_de = 5'd1; rt_de = 5'd5; uses_rt_de = 1'b1;
    @(negedge CLK);
    total_cnt++; if (ctl !== C_LU) $display("FAIL lu_rt got %b want %b", ctl, C_LU); else pass_cnt++;
    step(); exp_stall += 1; exp_flush += 1;
    set_idle(); step();
    set_lw(5'd5); rs_de = 5'd1; rt_de = 5'd5; uses_rt_de = 1'b0;
    @(negedge CLK);
    total_cnt++; if (ctl !== C_IDLE) $display("FAIL lu_rt_unused got %b want %b", ctl, C_IDLE); else pass_cnt++;
    step();
    opcode_de = 6'h3f; uses_rt_de = 1'b1;
    @(negedge CLK);
    total_cnt++; if (ctl !== C_IDLE) $display("FAIL jr_rt_ignored got %b want %b", ctl, C_IDLE); else pass_cnt++;
    step();
    rs_de = 5'd5;
    @(negedge CLK);
    total_cnt++; if (ctl !== C_LU) $display("FAIL jr_rs got %b want %b", ctl, C_LU); else pass_cnt++;
    step(); exp_stall += 1; exp_flush += 1;
    set_idle(); step();
    total_cnt++; if (stall_cnt !== 4'(exp_stall) || flush_cnt !== 4'(exp_flush))
      $display("FAIL lu_cnt2 got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush); else pass_cnt++;
  endtask

  task automatic test_zero();
    set_idle(); set_lw(5'd0); rs_de = 5'd0; rt_de = 5'd0; uses_rt_de = 1'b1;
    @(negedge CLK);
    total_cnt++; if (ctl !== C_IDLE) $display("FAIL zero_ctl got %b want %b", ctl, C_IDLE); else pass_cnt++;
    step();
    total_cnt++; if (stall_cnt !== 4'(exp_stall))
      $display("FAIL zero_cnt got %0d want %0d", stall_cnt, exp_stall); else pass_cnt++;
  endtask

  task automatic test_redirect();
    set_idle(); set_lw(5'd3); rs_de = 5'd3; redirect_ex = 1'b1;
    @(negedge CLK);
    total_cnt++; if (ctl !== C_REDIR) $display("FAIL redir_lu got %b want %b", ctl, C_REDIR); else pass_cnt++;
    step(); exp_flush += 1;
    set_idle(); redirect_ex = 1'b1; ihit = 1'b0;
    @(negedge CLK);
    total_cnt++; if (ctl !== C_REDIR) $display("FAIL redir_imiss got %b want %b", ctl, C_REDIR); else pass_cnt++;
    step(); exp_flush += 1;
    set_idle(); step();
    total_cnt++; if (stall_cnt !== 4'(exp_stall) || flush_cnt !== 4'(exp_flush))
      $display("FAIL redir_cnt got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush); else pass_cnt++;
  endtask

  task automatic test_dwait();
    set_idle(); dREN_me = 1'b1; set_lw(5'd3); rs_de = 5'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      total_cnt++; if (ctl !== C_FRZ) $display("FAIL dwait_c%0d got %b want %b", i, ctl, C_FRZ); else pass_cnt++;
      step(); exp_stall += 1;
    end
    set_idle(); dREN_me = 1'b1; dhit = 1'b1;
    @(negedge CLK);
    total_cnt++; if (ctl !== C_IDLE) $display("FAIL dwait_hit got %b want %b", ctl, C_IDLE); else pass_cnt++;
    step();
    set_idle(); set_lw(5'd3); rs_de = 5'd3;
    @(negedge CLK);
    total_cnt++; if (ctl !== C_LU) $display("FAIL dwait_back_run got %b want %b", ctl, C_LU); else pass_cnt++;
    step(); exp_stall += 1; exp_flush += 1;
    set_idle(); step();
    dWEN_me = 1'b1;
    @(negedge CLK);
    total_cnt++; if (ctl !== C_FRZ) $display("FAIL dwait_wr got %b want %b", ctl, C_FRZ); else pass_cnt++;
    step(); exp_stall += 1;
    dhit = 1'b1; step();
    set_idle();
    total_cnt++; if (stall_cnt !== 4'(exp_stall) || flush_cnt !== 4'(exp_flush))
      $display("FAIL dwait_cnt got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush); else pass_cnt++;
  endtask

  task automatic test_ifetch();
    set_idle(); ihit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      total_cnt++; if (ctl !== C_IMISS) $display("FAIL imiss_c%0d got %b want %b", i, ctl, C_IMISS); else pass_cnt++;
      step(); exp_stall += 1; exp_flush += 1;
    end
    set_idle();
    total_cnt++; if (stall_cnt !== 4'(exp_stall) || flush_cnt !== 4'(exp_flush))
      $display("FAIL imiss_cnt got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    set_idle(); dREN_me = 1'b1;
    step();
    nRST = 1'b0;
    @(negedge CLK);
    total_cnt++; if (ctl !== C_RST) $display("FAIL rstmid_ctl got %b want %b", ctl, C_RST); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0)
      $display("FAIL rstmid_cnt_read got %0d/%0d want 0/0", stall_cnt, flush_cnt); else pass_cnt++;
    step();
    set_idle(); set_lw(5'd3); rs_de = 5'd3;
    @(negedge CLK);
    total_cnt++; if (ctl !== C_LU) $display("FAIL rstmid_run got %b want %b", ctl, C_LU); else pass_cnt++;
    step(); exp_stall = 1; exp_flush = 1;
    total_cnt++; if (stall_cnt !== 4'(exp_stall) || flush_cnt !== 4'(exp_flush))
      $display("FAIL rstmid_cnt got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush); else pass_cnt++;
  endtask

  task automatic test_saturation();
    set_idle(); step(); ihit = 1'b0;
    repeat (14) step();
    total_cnt++; if (stall_cnt !== 4'hF || flush_cnt !== 4'hF)
      $display("FAIL sat_reach got %0d/%0d want 15/15", stall_cnt, flush_cnt); else pass_cnt++;
    repeat (6) step();
    total_cnt++; if (stall_cnt !== 4'hF || flush_cnt !== 4'hF)
      $display("FAIL sat_hold got %0d/%0d want 15/15", stall_cnt, flush_cnt); else pass_cnt++;
    set_idle();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_load_use();
    test_zero();
    test_redirect();
    test_dwait();
    test_ifetch();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
